// File: rtl/regfile.sv
// Purpose: 32x32 general-purpose register file plus HI/LO pair, with write-to-read bypass.
// Latency: reads are combinational (zero cycles); writes land on the next rising edge.
// Backpressure: none; one GPR write and one HI/LO write are accepted every cycle.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        hilo_we,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // Entry 0 is kept in the array for simple indexing but is never written
  // and is never returned: the read path forces address 0 to zero.
  logic [31:0] regs [0:31];
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // GPR storage: reset clears everything and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // HI/LO storage: both halves are always written together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'h0000_0000;
      lo_q <= 32'h0000_0000;
    end else if (hilo_we) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  // Read port 1: reset, disable and r0 force zero; a matching write is bypassed.
  always_comb begin
    rdata1 = 32'h0000_0000;
    if (rst) begin
      rdata1 = 32'h0000_0000;
    end else if (!re1) begin
      rdata1 = 32'h0000_0000;
    end else if (raddr1 == 5'd0) begin
      rdata1 = 32'h0000_0000;
    end else if (we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  // Read port 2: same priority as port 1, evaluated independently.
  always_comb begin
    rdata2 = 32'h0000_0000;
    if (rst) begin
      rdata2 = 32'h0000_0000;
    end else if (!re2) begin
      rdata2 = 32'h0000_0000;
    end else if (raddr2 == 5'd0) begin
      rdata2 = 32'h0000_0000;
    end else if (we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

  // HI/LO are shown straight from the registers; hazards are forwarded in execute.
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        hilo_we;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural contents after the most recent edge.
  logic [31:0] m_regs [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          hilo_known = 0;
  bit          checking   = 0;

  regfile dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re1     (re1),
    .raddr1  (raddr1),
    .rdata1  (rdata1),
    .re2     (re2),
    .raddr2  (raddr2),
    .rdata2  (rdata2),
    .hilo_we (hilo_we),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // What a read port must return given the current inputs and model state.
  function automatic logic [31:0] expect_read(input logic en, input logic [4:0] addr);
    if (rst) return 32'h0;
    if (!en) return 32'h0;
    if (addr == 5'd0) return 32'h0;
    if (we && addr == waddr) return wdata;
    return m_regs[addr];
  endfunction

  // Model update on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
      hilo_known = 1;
    end else begin
      if (we && waddr != 5'd0) m_regs[waddr] = wdata;
      if (hilo_we) begin
        m_hi = hi_i;
        m_lo = lo_i;
      end
    end
  end

  // Compare process: mid-cycle, after inputs driven at the falling edge have settled.
  always @(negedge clk) begin
    #3;
    if (checking) begin
      check("model_rdata1", rdata1, expect_read(re1, raddr1));
      check("model_rdata2", rdata2, expect_read(re2, raddr2));
      if (hilo_known) begin
        check("model_hi_o", hi_o, m_hi);
        check("model_lo_o", lo_o, m_lo);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                       input logic hw, input logic [31:0] hv, input logic [31:0] lv);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    hilo_we = hw; hi_i = hv; lo_i = lv;
    #2;
  endtask

  initial begin
    rst = 1; we = 0; waddr = 0; wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    hilo_we = 0; hi_i = 0; lo_i = 0;
    @(posedge clk);
    @(posedge clk);
    checking = 1;

    // Reset state
    drive(1, 0, 0, 0, 1, 5, 1, 6, 0, 0, 0);
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_hi", hi_o, 32'h0);

    // Reset clears r5 and HI/LO
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h1, 32'h2);
    drive(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    check("pre_reset_r5", rdata1, 32'hDEADBEEF);
    check("pre_reset_hi", hi_o, 32'h1);
    drive(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    check("reset_clear_r5", rdata1, 32'h0);
    check("reset_clear_hi", hi_o, 32'h0);
    check("reset_clear_lo", lo_o, 32'h0);

    // Basic write then read, then port disabled
    drive(0, 1, 7, 32'h12345678, 0, 7, 0, 0, 0, 0, 0);
    check("write_re_off", rdata1, 32'h0);
    drive(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
    check("basic_read_r7", rdata1, 32'h12345678);
    drive(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    check("basic_re1_off", rdata1, 32'h0);

    // r0 is hardwired
    drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 0);
    check("r0_same_cycle_p1", rdata1, 32'h0);
    check("r0_same_cycle_p2", rdata2, 32'h0);
    drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    check("r0_after_p1", rdata1, 32'h0);
    check("r0_after_p2", rdata2, 32'h0);

    // Bypass
    drive(0, 1, 9, 32'h11111111, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 9, 32'hAAAA5555, 1, 9, 1, 9, 0, 0, 0);
    check("bypass_p1", rdata1, 32'hAAAA5555);
    check("bypass_p2", rdata2, 32'hAAAA5555);
    drive(0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 0);
    check("bypass_after_p1", rdata1, 32'hAAAA5555);
    check("bypass_after_p2", rdata2, 32'hAAAA5555);
    drive(0, 1, 9, 32'h00000003, 1, 9, 0, 9, 0, 0, 0);
    check("bypass_re2_off_p1", rdata1, 32'h3);
    check("bypass_re2_off_p2", rdata2, 32'h0);

    // Reset vs write collision
    drive(0, 1, 3, 32'h5, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    check("collision_pre_r3", rdata2, 32'h5);
    drive(1, 1, 3, 32'h99, 1, 3, 0, 0, 0, 0, 0);
    check("collision_rst_read", rdata1, 32'h0);
    drive(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    check("collision_r3", rdata1, 32'h0);

    // HI/LO write, no bypass, then hold
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 32'h0BADBEEF);
    check("hilo_before_hi", hi_o, 32'h0);
    check("hilo_before_lo", lo_o, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12121212, 32'h34343434);
    check("hilo_after_hi", hi_o, 32'hCAFEF00D);
    check("hilo_after_lo", lo_o, 32'h0BADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("hilo_hold_hi", hi_o, 32'hCAFEF00D);
    check("hilo_hold_lo", lo_o, 32'h0BADBEEF);

    // Randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] wa;
      logic [4:0] a1;
      logic [4:0] a2;
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
            ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2,
            ($urandom_range(0, 3) == 0), $urandom, $urandom);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #4;
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
